// File: rtl/lifo_pop_stream.sv
// Drains bytes from a registered-read LIFO into a ready/valid stream through a 2-entry skid FIFO.
// A drain pops either a fixed number of bytes or until the stack reports empty.
module lifo_pop_stream #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] lifo_dataout,
  input  logic          lifo_empty,
  output logic          lifo_re,
  input  logic          drain_start,
  input  logic [CW-1:0] drain_len,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          short,
  output logic [CW-1:0] popped_cnt
);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  localparam logic [CW-1:0] CntMax = CW'(16);

  state_e        state_q;
  logic [1:0]    occ_q;
  logic [DW-1:0] buf0_q, buf1_q;
  logic          inflight_q;
  logic [CW-1:0] remaining_q;
  logic          len_zero_q;
  logic [CW-1:0] popped_q;
  logic          short_q;
  logic          done_q;

  logic          pop_out;
  logic [2:0]    occ_proj;

  // occ_proj is the occupancy after the next edge; a new pop is only allowed if the
  // byte it returns one cycle later is guaranteed a free slot.
  always_comb begin
    pop_out  = (occ_q != 2'd0) & m_ready;
    occ_proj = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};
    lifo_re  = (state_q == StDrain) & ~lifo_empty & (len_zero_q | (remaining_q != '0)) &
               (occ_proj < 3'd2);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      inflight_q  <= 1'b0;
      remaining_q <= '0;
      len_zero_q  <= 1'b0;
      popped_q    <= '0;
      short_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= lifo_re;

      // buf0 is always the oldest entry; simultaneous write and read keeps occupancy.
      case ({inflight_q, pop_out})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= lifo_dataout;
          else               buf1_q <= lifo_dataout;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= lifo_dataout;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= lifo_dataout;
          end
        end
        default: ;
      endcase

      if (pop_out && (popped_q != CntMax)) popped_q <= popped_q + 1'b1;
      if (lifo_re && !len_zero_q) remaining_q <= remaining_q - 1'b1;

      case (state_q)
        StIdle: begin
          if (drain_start) begin
            remaining_q <= drain_len;
            len_zero_q  <= (drain_len == '0);
            popped_q    <= '0;
            short_q     <= 1'b0;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (!len_zero_q && (remaining_q == '0)) begin
            state_q <= StFlush;
          end else if (lifo_empty && !inflight_q) begin
            state_q <= StFlush;
            if (!len_zero_q) short_q <= 1'b1;
          end
        end
        StFlush: begin
          if ((occ_q == 2'd0) && !inflight_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign short      = short_q;
  assign popped_cnt = popped_q;

endmodule

// File: tb/tb_lifo_pop_stream.sv
// Directed bench for lifo_pop_stream with a behavioural 16-deep registered-read stack.
module tb_lifo_pop_stream;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] lifo_dataout;
  logic       lifo_empty;
  logic       lifo_re;
  logic       drain_start;
  logic [4:0] drain_len;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic       short_w;
  logic [4:0] popped_cnt;

  int tests = 0;
  int fails = 0;

  // Stack model
  logic [7:0] smem [32];
  logic [4:0] scnt = 5'd0;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;

  logic [7:0] cap [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;

  lifo_pop_stream #(.DW(8), .CW(5)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .lifo_dataout (lifo_dataout),
    .lifo_empty   (lifo_empty),
    .lifo_re      (lifo_re),
    .drain_start  (drain_start),
    .drain_len    (drain_len),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done),
    .short        (short_w),
    .popped_cnt   (popped_cnt)
  );

  assign lifo_empty = (scnt == 5'd0);

  always @(posedge clk) begin
    if (lifo_re && scnt != 5'd0) begin
      lifo_dataout <= smem[scnt - 5'd1];
      scnt         <= scnt - 5'd1;
    end else if (push_en && scnt < 5'd16) begin
      smem[scnt] <= push_data;
      scnt       <= scnt + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: records accepted bytes and checks hold-while-stalled.
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (stall_q) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, stall_data});
      end
      if (m_valid && m_ready) cap.push_back(m_data);
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic push(input logic [7:0] d);
    push_en   = 1'b1;
    push_data = d;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic start(input logic [4:0] len);
    drain_start = 1'b1;
    drain_len   = len;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1);
  end

  initial begin
    int base;
    resetn      = 1'b0;
    drain_start = 1'b0;
    drain_len   = 5'd0;
    m_ready     = 1'b1;
    #2;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_w, 0);
    check("rst_cnt", popped_cnt, 0);
    check("rst_re", lifo_re, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Drain-until-empty, first byte on the third cycle after start is sampled
    push(8'hA1); push(8'hB2); push(8'hC3);
    base = cap.size();
    start(5'd0);
    check("t1_busy", busy, 1);
    check("t1_re", lifo_re, 1);
    check("t1_lat1", m_valid, 0);
    @(negedge clk); check("t1_lat2", m_valid, 0);
    @(negedge clk); check("t1_v0", m_valid, 1); check("t1_d0", m_data, 8'hC3);
    @(negedge clk); check("t1_v1", m_valid, 1); check("t1_d1", m_data, 8'hB2);
    @(negedge clk); check("t1_v2", m_valid, 1); check("t1_d2", m_data, 8'hA1);
    wait_done(50);
    check("t1_cnt", popped_cnt, 3);
    check("t1_short", short_w, 0);
    check("t1_idle", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_ncap", cap.size() - base, 3);

    // Length mode: 2 of 5
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    base = cap.size();
    start(5'd2);
    wait_done(50);
    check("t2_ncap", cap.size() - base, 2);
    check("t2_b0", cap[base], 8'h55);
    check("t2_b1", cap[base+1], 8'h44);
    check("t2_left", scnt, 3);
    check("t2_short", short_w, 0);
    check("t2_cnt", popped_cnt, 2);
    base = cap.size();
    start(5'd0);
    wait_done(50);
    check("t2_rest_n", cap.size() - base, 3);
    check("t2_rest_b0", cap[base], 8'h33);

    // Length longer than stack -> short
    push(8'hA5); push(8'h5A);
    base = cap.size();
    start(5'd4);
    wait_done(50);
    check("t3_ncap", cap.size() - base, 2);
    check("t3_b0", cap[base], 8'h5A);
    check("t3_b1", cap[base+1], 8'hA5);
    check("t3_short", short_w, 1);
    check("t3_cnt", popped_cnt, 2);
    @(negedge clk);
    check("t3_short_hold", short_w, 1);

    // Full stack with m_ready toggling
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    base = cap.size();
    start(5'd0);
    check("t4_short_clr", short_w, 0);
    for (int n = 0; n < 400 && !done; n++) begin
      m_ready = ~m_ready;
      @(negedge clk);
    end
    check("t4_done", done, 1);
    m_ready = 1'b1;
    check("t4_ncap", cap.size() - base, 16);
    for (int i = 0; i < 16; i++) check("t4_order", cap[base+i], 8'h8F - 8'(i));
    check("t4_cnt_sat", popped_cnt, 16);

    // Start while busy is ignored
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    base = cap.size();
    start(5'd3);
    check("t5_busy", busy, 1);
    drain_start = 1'b1;
    drain_len   = 5'd0;
    @(negedge clk);
    drain_start = 1'b0;
    wait_done(50);
    check("t5_ncap", cap.size() - base, 3);
    check("t5_b2", cap[base+2], 8'h42);
    check("t5_cnt", popped_cnt, 3);
    check("t5_left", scnt, 1);
    base = cap.size();
    start(5'd0);
    wait_done(50);
    check("t5_rest", cap[base], 8'h41);

    // Asynchronous reset with the buffer full
    push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65); push(8'h66);
    m_ready = 1'b0;
    start(5'd0);
    repeat (5) @(negedge clk);
    check("t6_full_v", m_valid, 1);
    check("t6_full_d", m_data, 8'h66);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_data", m_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_re", lifo_re, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_short", short_w, 0);
    check("t6_rst_cnt", popped_cnt, 0);
    @(negedge clk);
    resetn  = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("t6_left", scnt, 4);
    base = cap.size();
    start(5'd0);
    check("t6_lat1", m_valid, 0);
    @(negedge clk); check("t6_lat2", m_valid, 0);
    @(negedge clk); check("t6_d0", m_data, 8'h64);
    @(negedge clk); check("t6_d1", m_data, 8'h63);
    @(negedge clk); check("t6_d2", m_data, 8'h62);
    @(negedge clk); check("t6_d3", m_data, 8'h61);
    wait_done(50);
    check("t6_cnt", popped_cnt, 4);
    check("t6_short", short_w, 0);
    check("t6_ncap", cap.size() - base, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
